// File: rtl/decoder_1x2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// state encoding, default parameter values and the tie-break helper.
package decoder_1x2_rr_arbiter_pkg;

    // Arbiter state encoding. 2'b11 is unused and is steered back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } arb_state_e;

    // Default hold limit and hold counter width.
    localparam int MAX_HOLD_DEF = 15;
    localparam int CNT_W_DEF    = 4;

    // Pick the next owner from a non-zero request vector.
    // A single request wins outright; a tie goes to the priority pointer.
    function automatic logic pick_owner(input logic [1:0] req, input logic prio);
        logic sel;
        case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = prio;
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/decoder_1x2_rr_arbiter_nand.sv
// 1-to-2 decoder built from NAND terms: sel=0 drives y=01, sel=1 drives y=10.
// The arbiter gates its output, so this block has no enable of its own.
module decoder_1x2_nand (
    input  logic       sel,
    output logic [1:0] y
);

    logic sel_n;

    // Inverter formed as a NAND with both inputs tied together.
    assign sel_n = ~(sel & sel);

    // Line 0 is selected by the inverted select, line 1 by a second inversion.
    assign y[0] = sel_n;
    assign y[1] = ~(sel_n & sel_n);

endmodule

// File: rtl/decoder_1x2_rr_arbiter.sv
// Two-requester round-robin arbiter with hold-time limiting and a one-cycle
// break-before-make gap. The registered owner bit is expanded to a one-hot
// grant by the NAND decoder and gated so that gnt is 00 outside GRANT.
// All outputs come straight from flops or from flops through the decoder;
// req/rel only influence the next state.
module decoder_1x2_rr_arbiter
    import decoder_1x2_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] rel,
    output logic [1:0] gnt,
    output logic       owner,
    output logic       busy,
    output logic       timeout
);

    // The revoke compares against MAX_HOLD-1, so the counter must be able
    // to hold that value without wrapping.
    generate
        if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
            $error("decoder_1x2_rr_arbiter: MAX_HOLD=%0d is outside 1..%0d for CNT_W=%0d",
                   MAX_HOLD, (2 ** CNT_W) - 1, CNT_W);
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic             owner_rel;
    logic             owner_drop;
    logic             hold_last;
    logic [1:0]       dec_raw;

    // Exit conditions seen from the current owner only; the other rel bit
    // is never looked at.
    assign owner_rel  = rel[owner_q];
    assign owner_drop = ~req[owner_q];
    assign hold_last  = (hold_cnt_q == HOLD_LAST);

    // Next-state, owner, priority pointer, hold counter and timeout pulse.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    owner_d    = pick_owner(req, prio_q);
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end

            ST_GRANT: begin
                hold_cnt_d = hold_cnt_q + CNT_ONE;
                if (owner_rel || owner_drop || hold_last) begin
                    state_d    = ST_GAP;
                    prio_d     = ~owner_q;
                    hold_cnt_d = '0;
                    // A voluntary release or abandon on the limit cycle is
                    // not a forced revoke, so no pulse in that case.
                    timeout_d  = hold_last & ~owner_rel & ~owner_drop;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner, pointer, counter and pulse registers with sync reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Raw one-hot for the registered owner.
    decoder_1x2_nand u_dec (
        .sel (owner_q),
        .y   (dec_raw)
    );

    assign busy    = (state_q == ST_GRANT);
    assign gnt     = dec_raw & {2{busy}};
    assign owner   = owner_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_1x2_rr_arbiter.sv
// Bench for decoder_1x2_rr_arbiter: directed scenarios with literal
// expectations, then randomized req/rel/rst traffic, all checked every
// cycle against a behavioural model of the arbitration rules.
module tb_decoder_1x2_rr_arbiter;

    localparam int TB_MAX_HOLD = 4;
    localparam int TB_CNT_W    = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] rel = 2'b00;
    logic [1:0] gnt;
    logic       owner;
    logic       busy;
    logic       timeout;

    always #5 clk = ~clk;

    decoder_1x2_rr_arbiter #(
        .MAX_HOLD (TB_MAX_HOLD),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;
    int n_timeouts = 0;
    int n_grants   = 0;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = resource free, 1 = held, 2 = cooling-off cycle.
    // held_for counts cycles the current holder has already held it.
    int   m_phase    = 0;
    int   m_holder   = 0;
    int   m_next_tie = 0;
    int   m_held_for = 0;
    bit   m_revoked  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase    = 0;
            m_holder   = 0;
            m_next_tie = 0;
            m_held_for = 0;
            m_revoked  = 1'b0;
        end else begin
            m_revoked = 1'b0;
            if (m_phase == 0) begin
                if (req == 2'b11) begin
                    m_holder = m_next_tie;
                    m_phase  = 1;
                    m_held_for = 0;
                end else if (req != 2'b00) begin
                    m_holder = (req == 2'b10) ? 1 : 0;
                    m_phase  = 1;
                    m_held_for = 0;
                end
            end else if (m_phase == 1) begin
                m_held_for = m_held_for + 1;
                if (rel[m_holder] || !req[m_holder] || m_held_for >= TB_MAX_HOLD) begin
                    m_revoked  = !rel[m_holder] && req[m_holder];
                    m_phase    = 2;
                    m_next_tie = 1 - m_holder;
                    if (m_revoked) n_timeouts++;
                    n_grants++;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [1:0] exp_gnt;
        if (check_en) begin
            exp_gnt = (m_phase == 1) ? ((m_holder == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("gnt", gnt, exp_gnt);
            chk("owner", {1'b0, owner}, 2'(m_holder));
            chk("busy", {1'b0, busy}, {1'b0, m_phase == 1});
            chk("timeout", {1'b0, timeout}, {1'b0, m_revoked});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] exp;

        // Reset with both requests high: nothing may be granted.
        rst = 1'b1;
        req = 2'b11;
        step();
        check_en = 1'b1;
        step();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_owner", {1'b0, owner}, 2'b00);
        chk("rst_busy", {1'b0, busy}, 2'b00);
        chk("rst_timeout", {1'b0, timeout}, 2'b00);
        rst = 1'b0;
        req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_gnt", gnt, 2'b00);
        end

        // Single requester 1, releases on its 4th grant cycle.
        req = 2'b10;
        step();
        chk("single_first", gnt, 2'b10);
        step();
        step();
        step();
        chk("single_hold", gnt, 2'b10);
        rel = 2'b10;
        step();
        chk("single_gap", gnt, 2'b00);
        req = 2'b00;
        rel = 2'b00;
        step();
        chk("single_idle", gnt, 2'b00);

        // Tie with alternation, each owner releasing on its 3rd cycle.
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1) ? 2'b10 : 2'b01;
            step();
            chk("alt_grant", gnt, exp);
            step();
            step();
            chk("alt_third", gnt, exp);
            rel = exp;
            step();
            chk("alt_gap", gnt, 2'b00);
            rel = 2'b00;
            step();
            chk("alt_idle", gnt, 2'b00);
        end

        // Forced revoke after TB_MAX_HOLD cycles, then re-grant to 0.
        do_reset();
        req = 2'b01;
        for (int i = 0; i < TB_MAX_HOLD; i++) begin
            step();
            chk("to_hold", gnt, 2'b01);
            chk("to_nopulse", {1'b0, timeout}, 2'b00);
        end
        step();
        chk("to_gap_gnt", gnt, 2'b00);
        chk("to_pulse", {1'b0, timeout}, 2'b01);
        step();
        chk("to_idle_gnt", gnt, 2'b00);
        chk("to_pulse_end", {1'b0, timeout}, 2'b00);
        step();
        chk("to_regrant", gnt, 2'b01);

        // Non-owner release is ignored, then abandon.
        do_reset();
        req = 2'b01;
        step();
        rel = 2'b10;
        step();
        chk("nonowner_rel", gnt, 2'b01);
        rel = 2'b00;
        step();
        req = 2'b00;
        step();
        chk("abandon_gap", gnt, 2'b00);
        chk("abandon_to", {1'b0, timeout}, 2'b00);
        req = 2'b11;
        step();
        chk("abandon_idle", gnt, 2'b00);
        step();
        chk("abandon_prio", gnt, 2'b10);

        // Reset while owner 1 holds at hold count 2.
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_gnt", gnt, 2'b00);
        chk("midrst_to", {1'b0, timeout}, 2'b00);
        rst = 1'b0;
        step();
        chk("midrst_first", gnt, 2'b01);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            rel = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        req = 2'b00;
        rel = 2'b00;
        step();
        step();

        if (n_timeouts == 0 || n_grants == 0) begin
            total++;
            bad++;
            $display("FAIL coverage: timeouts=%0d grants=%0d required both nonzero", n_timeouts, n_grants);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
